iexecute: RTL and testbench

Execute stage of the five-stage LEGv8 pipeline, between instruction decode and the memory stage.
- Captures decoded operands and control into an input buffer on each clock edge.
- Computes the ALU result, zero flag and branch target, and passes through the control bits the memory stage needs.
- Adds an iterative 64-cycle shift-add multiplier, with a busy handshake that stalls decode while a MUL is in flight.

---
 rtl/iexecute.sv | 158 +++++++++++++++
 tb/tb_iexecute.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/iexecute.sv
// Execute stage of the LEGv8 pipeline: input buffer, single-cycle ALU,
// branch-target adder and an iterative 64-step shift-add multiplier.
// A MUL holds the stage busy for 64 cycles, and decode stalls on busy.

`ifndef WORD
`define WORD 64
`endif

module iexecute (
  input  logic              ie_clk,
  input  logic              reset,
  input  logic [`WORD-1:0]  pc_in,
  input  logic [`WORD-1:0]  read_data1,
  input  logic [`WORD-1:0]  read_data2_in,
  input  logic [`WORD-1:0]  sign_ext_imm,
  input  logic [3:0]        alu_control,
  input  logic              alu_src,
  input  logic              uncond_branch,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        write_reg_in,
  input  logic              flush,
  output logic [`WORD-1:0]  pc_out,
  output logic [`WORD-1:0]  alu_result,
  output logic              zero,
  output logic [`WORD-1:0]  read_data2,
  output logic              uncond_branch_out,
  output logic              branch_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic [4:0]        write_reg_out,
  output logic              busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t state, state_nxt;

  // Input buffer
  logic [`WORD-1:0] pc_buf, a_buf, rd2_buf, imm_buf;
  logic [3:0]       op_buf;
  logic             src_buf;
  logic [5:0]       ctrl_buf;   // {uncond, branch, mem_read, mem_write, mem_to_reg, reg_write}
  logic [4:0]       wr_buf;

  // Multiplier state
  logic [`WORD-1:0] mcand, mplier, acc, acc_nxt, product;
  logic [5:0]       count;

  logic             capture, start_mul;
  logic [`WORD-1:0] op_b;

  assign busy      = (state == MUL_RUN);
  assign capture   = (state == IDLE);
  assign start_mul = capture && (alu_control == OP_MUL) && !flush;
  assign acc_nxt   = mplier[0] ? (acc + mcand) : acc;

  // State register
  always_ff @(posedge ie_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start on an unflushed MUL capture, finish after step 63
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mul) state_nxt = MUL_RUN;
      MUL_RUN: if (count == 6'd63) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input buffer: load when not busy, flush zeroes only the control bits
  always_ff @(posedge ie_clk or posedge reset) begin
    if (reset) begin
      pc_buf   <= '0;
      a_buf    <= '0;
      rd2_buf  <= '0;
      imm_buf  <= '0;
      op_buf   <= '0;
      src_buf  <= 1'b0;
      ctrl_buf <= '0;
      wr_buf   <= '0;
    end else if (capture) begin
      pc_buf   <= pc_in;
      a_buf    <= read_data1;
      rd2_buf  <= read_data2_in;
      imm_buf  <= sign_ext_imm;
      op_buf   <= alu_control;
      src_buf  <= alu_src;
      ctrl_buf <= flush ? 6'b0 : {uncond_branch, branch, mem_read,
                                  mem_write, mem_to_reg_in, reg_write_in};
      wr_buf   <= write_reg_in;
    end
  end

  // Shift-add multiplier: one multiplier bit per cycle, product on the last step
  always_ff @(posedge ie_clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
      count   <= '0;
    end else if (start_mul) begin
      mcand  <= read_data1;
      mplier <= alu_src ? sign_ext_imm : read_data2_in;
      acc    <= '0;
      count  <= '0;
    end else if (state == MUL_RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 6'd1;
      if (count == 6'd63) product <= acc_nxt;
    end
  end

  // ALU on buffered operands; MUL reports the last registered product
  always_comb begin
    op_b       = src_buf ? imm_buf : rd2_buf;
    alu_result = '0;
    case (op_buf)
      OP_AND:  alu_result = a_buf & op_b;
      OP_ORR:  alu_result = a_buf | op_b;
      OP_ADD:  alu_result = a_buf + op_b;
      OP_SUB:  alu_result = a_buf - op_b;
      OP_PASS: alu_result = op_b;
      OP_NOR:  alu_result = ~(a_buf | op_b);
      OP_MUL:  alu_result = product;
      default: alu_result = '0;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign pc_out        = pc_buf + (imm_buf << 2);
  assign read_data2    = rd2_buf;
  assign write_reg_out = wr_buf;

  // Memory stage sees bubbles while the multiplier runs
  assign {uncond_branch_out, branch_out, mem_read_out,
          mem_write_out, mem_to_reg_out, reg_write_out} = busy ? 6'b0 : ctrl_buf;

endmodule

// File: tb/tb_iexecute.sv
// Directed bench for the execute stage: ALU ops, branch target, flush,
// multiplier timing, back-to-back MULs and reset abort.
`timescale 1ns/1ps

module tb_iexecute;

  logic        ie_clk = 1'b0;
  logic        reset;
  logic [63:0] pc_in, read_data1, read_data2_in, sign_ext_imm;
  logic [3:0]  alu_control;
  logic        alu_src;
  logic        uncond_branch, branch, mem_read, mem_write, mem_to_reg_in, reg_write_in;
  logic [4:0]  write_reg_in;
  logic        flush;
  logic [63:0] pc_out, alu_result, read_data2;
  logic        zero;
  logic        uncond_branch_out, branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out;
  logic [4:0]  write_reg_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 ie_clk = ~ie_clk;

  iexecute dut (
    .ie_clk(ie_clk), .reset(reset), .pc_in(pc_in), .read_data1(read_data1),
    .read_data2_in(read_data2_in), .sign_ext_imm(sign_ext_imm),
    .alu_control(alu_control), .alu_src(alu_src),
    .uncond_branch(uncond_branch), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .write_reg_in(write_reg_in), .flush(flush),
    .pc_out(pc_out), .alu_result(alu_result), .zero(zero), .read_data2(read_data2),
    .uncond_branch_out(uncond_branch_out), .branch_out(branch_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .write_reg_out(write_reg_out), .busy(busy)
  );

  function automatic logic [5:0] ctrl_obs();
    return {uncond_branch_out, branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out};
  endfunction

  // ctrl = {uncond, branch, mem_read, mem_write, mem_to_reg, reg_write}
  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] imm, input logic src, input logic [63:0] pc,
                       input logic [5:0] ctrl, input logic [4:0] wr, input logic fl);
    alu_control = op; read_data1 = a; read_data2_in = b; sign_ext_imm = imm;
    alu_src = src; pc_in = pc; write_reg_in = wr; flush = fl;
    {uncond_branch, branch, mem_read, mem_write, mem_to_reg_in, reg_write_in} = ctrl;
  endtask

  task automatic tick();
    @(posedge ie_clk); #1;
  endtask

  task automatic test_reset();
    drive(4'b0010, 64'd5, 64'd9, 64'd3, 1'b1, 64'h40, 6'b111111, 5'd7, 1'b0);
    tick();
    #3 reset = 1'b1;
    #1;
    vectors++; if (alu_result !== 64'd0) begin miscompares++; $display("FAIL reset_alu_result got %h want 0", alu_result); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b want 1", zero); end
    vectors++; if (pc_out !== 64'd0) begin miscompares++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
    vectors++; if (read_data2 !== 64'd0) begin miscompares++; $display("FAIL reset_read_data2 got %h want 0", read_data2); end
    vectors++; if (write_reg_out !== 5'd0) begin miscompares++; $display("FAIL reset_write_reg got %0d want 0", write_reg_out); end
    vectors++; if (ctrl_obs() !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl got %b want 000000", ctrl_obs()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    #2 reset = 1'b0;
    drive(4'b0000, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 6'b0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_add_imm();
    drive(4'b0010, 64'd5, 64'd100, 64'd3, 1'b1, 64'd0, 6'b000001, 5'd4, 1'b0);
    tick();
    vectors++; if (alu_result !== 64'd8) begin miscompares++; $display("FAIL add_imm_result got %0d want 8", alu_result); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL add_imm_zero got %b want 0", zero); end
    vectors++; if (reg_write_out !== 1'b1) begin miscompares++; $display("FAIL add_imm_reg_write got %b want 1", reg_write_out); end
    vectors++; if (read_data2 !== 64'd100) begin miscompares++; $display("FAIL add_imm_rd2 got %0d want 100", read_data2); end
    vectors++; if (write_reg_out !== 5'd4) begin miscompares++; $display("FAIL add_imm_wr got %0d want 4", write_reg_out); end
  endtask

  task automatic test_sub();
    drive(4'b0110, 64'h10, 64'h10, 64'd0, 1'b0, 64'd0, 6'b0, 5'd1, 1'b0);
    tick();
    vectors++; if (alu_result !== 64'd0) begin miscompares++; $display("FAIL sub_eq_result got %h want 0", alu_result); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL sub_eq_zero got %b want 1", zero); end
    drive(4'b0110, 64'd0, 64'd1, 64'd0, 1'b0, 64'd0, 6'b0, 5'd1, 1'b0);
    tick();
    vectors++; if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL sub_wrap got %h want ffffffffffffffff", alu_result); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL sub_wrap_zero got %b want 0", zero); end
  endtask

  task automatic test_logic();
    logic [3:0]  ops  [5] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011};
    logic [63:0] as   [5] = '{64'hF0F0, 64'hF0F0, 64'h0, 64'h55, 64'h7};
    logic [63:0] bs   [5] = '{64'hFF00, 64'hFF00, 64'h0, 64'h99, 64'h7};
    logic        srcs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] exp  [5] = '{64'hF000, 64'hFFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'h0};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i], 64'h1234, srcs[i], 64'd0, 6'b0, 5'd2, 1'b0);
      tick();
      vectors++;
      if (alu_result !== exp[i] || zero !== (exp[i] == 64'd0)) begin
        miscompares++;
        $display("FAIL logic_op%0d got %h/z%b want %h", i, alu_result, zero, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    drive(4'b0111, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h100, 6'b010000, 5'd0, 1'b0);
    tick();
    vectors++; if (pc_out !== 64'hF0) begin miscompares++; $display("FAIL branch_target got %h want f0", pc_out); end
    vectors++; if (branch_out !== 1'b1) begin miscompares++; $display("FAIL branch_out got %b want 1", branch_out); end
  endtask

  task automatic test_flush();
    drive(4'b0010, 64'd2, 64'd3, 64'd0, 1'b0, 64'd0, 6'b111111, 5'd6, 1'b1);
    tick();
    vectors++; if (mem_write_out !== 1'b0) begin miscompares++; $display("FAIL flush_mem_write got %b want 0", mem_write_out); end
    vectors++; if (ctrl_obs() !== 6'b0) begin miscompares++; $display("FAIL flush_ctrl got %b want 000000", ctrl_obs()); end
    vectors++; if (alu_result !== 64'd5) begin miscompares++; $display("FAIL flush_data got %0d want 5", alu_result); end
    // A flushed MUL must not start the multiplier
    drive(4'b1000, 64'd3, 64'd3, 64'd0, 1'b0, 64'd0, 6'b000001, 5'd6, 1'b1);
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_mul_busy got %b want 0", busy); end
    drive(4'b0000, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 6'b0, 5'd0, 1'b0);
  endtask

  // Runs one MUL captured at the next edge; the follow-up instruction is
  // presented during the run and must not be taken until the MUL completes.
  task automatic run_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] want, input logic want_zero);
    int busy_bad = 0;
    drive(4'b1000, a, b, 64'd0, 1'b0, 64'd0, 6'b000001, 5'd3, 1'b0);
    tick(); // edge k
    vectors++; if (busy !== 1'b1 || ctrl_obs() !== 6'b0) begin miscompares++; $display("FAIL %s_start busy %b ctrl %b want 1/000000", name, busy, ctrl_obs()); end
    drive(4'b0010, 64'd1, 64'd1, 64'd0, 1'b0, 64'd0, 6'b000001, 5'd9, 1'b0);
    for (int i = 1; i <= 63; i++) begin
      tick();
      if (busy !== 1'b1 || ctrl_obs() !== 6'b0 || write_reg_out !== 5'd3) busy_bad++;
    end
    vectors++; if (busy_bad != 0) begin miscompares++; $display("FAIL %s_run %0d bad cycles want 0", name, busy_bad); end
    tick(); // edge k+64
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_done_busy got %b want 0", name, busy); end
    vectors++; if (alu_result !== want || zero !== want_zero) begin miscompares++; $display("FAIL %s_product got %h/z%b want %h/z%b", name, alu_result, zero, want, want_zero); end
    vectors++; if (reg_write_out !== 1'b1 || write_reg_out !== 5'd3) begin miscompares++; $display("FAIL %s_ctrl got rw%b wr%0d want 1/3", name, reg_write_out, write_reg_out); end
  endtask

  task automatic test_mul();
    run_mul("mul_7x6", 64'd7, 64'd6, 64'd42, 1'b0);
    tick(); // edge k+65 takes the held ADD
    vectors++; if (alu_result !== 64'd2 || write_reg_out !== 5'd9) begin miscompares++; $display("FAIL mul_next_capture got %0d wr%0d want 2/9", alu_result, write_reg_out); end
  endtask

  task automatic test_back_to_back();
    run_mul("mul_ovf", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1);
    run_mul("mul_neg", 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    tick();
  endtask

  task automatic test_reset_abort();
    drive(4'b1000, 64'd7, 64'd6, 64'd0, 1'b0, 64'd0, 6'b000001, 5'd3, 1'b0);
    tick();
    drive(4'b0010, 64'd5, 64'd0, 64'd3, 1'b1, 64'd0, 6'b000001, 5'd4, 1'b0);
    repeat (10) @(posedge ie_clk);
    #3 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if (alu_result !== 64'd0 || zero !== 1'b1) begin miscompares++; $display("FAIL abort_result got %h/z%b want 0/z1", alu_result, zero); end
    #1 reset = 1'b0;
    tick();
    vectors++; if (alu_result !== 64'd8 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_fresh got %0d busy %b want 8/0", alu_result, busy); end
    run_mul("mul_after_abort", 64'd3, 64'd5, 64'd15, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 6'b0, 5'd0, 1'b0);
    #12 reset = 1'b0;
    tick();
    test_reset();
    test_add_imm();
    test_sub();
    test_logic();
    test_branch();
    test_flush();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
